// File: rtl/adder_sched_pkg.sv
// Shared types for the round-robin adder scheduler.
// Tags are sized for the largest supported requester count.
package adder_sched_pkg;

   localparam int C_DATA_WIDTH  = 8;
   localparam int C_NUM_REQ     = 4;
   localparam int C_ADD_LATENCY = 1;

   // Wide enough to tag up to 16 requesters.
   localparam int C_TAG_W = 4;

   typedef logic [C_TAG_W-1:0] tag_t;

   typedef struct packed {
      logic valid;
      tag_t idx;
   } tag_stage_t;

endpackage

// File: rtl/adder_rr_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// The scan starts at ptr and wraps; the pointer register lives in the parent.
import adder_sched_pkg::*;

module rr_arbiter #(
   parameter int G_N = C_NUM_REQ
) (
   input  logic [G_N-1:0] req,
   input  tag_t           ptr,
   output logic [G_N-1:0] grant,
   output tag_t           idx,
   output logic           any
);

   always_comb begin
      int j;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int off = 0; off < G_N; off++) begin
         j = (int'(ptr) + off) % G_N;
         if (!any && req[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = tag_t'(j);
         end
      end
   end

endmodule

// File: rtl/adder_rr_sched.sv
// Shares one registered adder between requesters, round-robin.
// Issued operations are tagged and results routed back to held response registers.
import adder_sched_pkg::*;

module adder_rr_sched #(
   parameter int G_DATA_WIDTH  = C_DATA_WIDTH,
   parameter int G_NUM_REQ     = C_NUM_REQ,
   parameter int G_ADD_LATENCY = C_ADD_LATENCY
) (
   input  logic                                i_clk,
   input  logic                                i_rst,
   input  logic [G_NUM_REQ-1:0]                i_req_valid,
   input  logic [G_NUM_REQ*G_DATA_WIDTH-1:0]   i_req_A,
   input  logic [G_NUM_REQ*G_DATA_WIDTH-1:0]   i_req_B,
   output logic [G_NUM_REQ-1:0]                o_req_ready,
   output logic [G_NUM_REQ-1:0]                o_rsp_valid,
   output logic [G_NUM_REQ*(G_DATA_WIDTH+1)-1:0] o_rsp_C,
   input  logic [G_NUM_REQ-1:0]                i_rsp_ready,
   output logic                                o_add_valid,
   output logic [G_DATA_WIDTH-1:0]             o_add_A,
   output logic [G_DATA_WIDTH-1:0]             o_add_B,
   input  logic                                i_add_valid,
   input  logic [G_DATA_WIDTH:0]               i_add_C,
   output logic                                o_err
);

   localparam int W = G_DATA_WIDTH;
   localparam int N = G_NUM_REQ;
   localparam int L = G_ADD_LATENCY;

   tag_t           ptr;
   tag_t           idx;
   logic           any;
   logic [N-1:0]   elig;
   logic [N-1:0]   grant;
   logic [N-1:0]   inflight;
   logic [N-1:0]   pending;
   logic [W:0]     rsp_c [N];
   tag_stage_t     pipe [L];
   tag_stage_t     tail;
   logic           cap;
   logic           err;

   // Held low during reset so no grant is visible while clearing.
   assign elig = i_req_valid & ~inflight & ~pending & {N{~i_rst}};

   rr_arbiter #(
      .G_N (N)
   ) u_arb (
      .req   (elig),
      .ptr   (ptr),
      .grant (grant),
      .idx   (idx),
      .any   (any)
   );

   assign o_req_ready = grant;
   assign o_add_valid = any;
   assign o_rsp_valid = pending;
   assign o_err       = err;

   assign tail = pipe[L-1];
   assign cap  = tail.valid && i_add_valid;

   always_comb begin
      o_add_A = '0;
      o_add_B = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) begin
            o_add_A = i_req_A[i*W +: W];
            o_add_B = i_req_B[i*W +: W];
         end
      end
   end

   always_comb begin
      inflight = '0;
      for (int s = 0; s < L; s++) begin
         for (int i = 0; i < N; i++) begin
            if (pipe[s].valid && pipe[s].idx == tag_t'(i)) begin
               inflight[i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      o_rsp_C = '0;
      for (int i = 0; i < N; i++) begin
         o_rsp_C[i*(W+1) +: W+1] = rsp_c[i];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ptr <= '0;
      end else if (any) begin
         ptr <= tag_t'((int'(idx) + 1) % N);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int s = 0; s < L; s++) begin
            pipe[s] <= '0;
         end
      end else begin
         pipe[0] <= {any, idx};
         for (int s = 1; s < L; s++) begin
            pipe[s] <= pipe[s-1];
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pending <= '0;
         for (int i = 0; i < N; i++) begin
            rsp_c[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (pending[i] && i_rsp_ready[i]) begin
               pending[i] <= 1'b0;
            end
            if (cap && tail.idx == tag_t'(i)) begin
               pending[i] <= 1'b1;
               rsp_c[i]   <= i_add_C;
            end
         end
      end
   end

   // Strobe and end-stage tag must agree every cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         err <= 1'b0;
      end else if (i_add_valid != tail.valid) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_adder_rr_sched.sv
// Randomized and directed bench for adder_rr_sched with a
// transaction-level scoreboard and a behavioural one-cycle adder.
module tb_adder_rr_sched;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   vld;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic [N-1:0]   rrdy;
   logic [N-1:0]   ready;
   logic [N-1:0]   rsp_v;
   logic [N*(W+1)-1:0] rsp_c;
   logic           add_valid;
   logic [W-1:0]   add_a;
   logic [W-1:0]   add_b;
   logic           add_v_q;
   logic [W:0]     add_c_q;
   logic           inj;
   logic           err;

   adder_rr_sched #(
      .G_DATA_WIDTH  (W),
      .G_NUM_REQ     (N),
      .G_ADD_LATENCY (1)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (vld),
      .i_req_A     (req_a),
      .i_req_B     (req_b),
      .o_req_ready (ready),
      .o_rsp_valid (rsp_v),
      .o_rsp_C     (rsp_c),
      .i_rsp_ready (rrdy),
      .o_add_valid (add_valid),
      .o_add_A     (add_a),
      .o_add_B     (add_b),
      .i_add_valid (add_v_q | inj),
      .i_add_C     (add_c_q),
      .o_err       (err)
   );

   always #5 clk = ~clk;

   // The shared adder: one registered stage.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         add_v_q <= 1'b0;
         add_c_q <= '0;
      end else begin
         add_v_q <= add_valid;
         add_c_q <= {1'b0, add_a} + {1'b0, add_b};
      end
   end

   int         n_chk = 0;
   int         n_pass = 0;
   int         cyc = 0;
   int         ptr_m = 0;
   bit         busy [N];
   int         due [N];
   logic [W:0] res [N];
   bit         err_m = 0;
   logic [N-1:0] last_g;
   int         cnt [N];

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
   endtask

   task automatic step();
      int k;
      int j;
      bit ev [N];
      #1;
      k = -1;
      if (rst) begin
         ptr_m = 0;
         err_m = 0;
         for (int i = 0; i < N; i++) busy[i] = 0;
      end else begin
         for (int off = 0; off < N; off++) begin
            j = (ptr_m + off) % N;
            if (k < 0 && vld[j] && !busy[j]) k = j;
         end
      end
      chk("ready", 64'(ready), k >= 0 ? 64'(1 << k) : 64'd0);
      chk("add_valid", 64'(add_valid), 64'(k >= 0));
      chk("add_a", 64'(add_a), k >= 0 ? 64'(req_a[k*W +: W]) : 64'd0);
      chk("add_b", 64'(add_b), k >= 0 ? 64'(req_b[k*W +: W]) : 64'd0);
      chk("err", 64'(err), 64'(err_m));
      for (int i = 0; i < N; i++) begin
         ev[i] = !rst && busy[i] && cyc >= due[i];
         chk($sformatf("rsp_valid%0d", i), 64'(rsp_v[i]), 64'(ev[i]));
         if (ev[i]) chk($sformatf("rsp_c%0d", i),
                        64'(rsp_c[i*(W+1) +: W+1]), 64'(res[i]));
      end
      if (rst) chk("rst_rsp_c", 64'(rsp_c), 64'd0);
      last_g = '0;
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            if (ev[i] && rrdy[i]) busy[i] = 0;
         end
         if (k >= 0) begin
            busy[k] = 1;
            due[k]  = cyc + 2;
            res[k]  = {1'b0, req_a[k*W +: W]} + {1'b0, req_b[k*W +: W]};
            ptr_m   = (k + 1) % N;
            last_g[k] = 1'b1;
            cnt[k]++;
         end
         if (inj) err_m = 1;
      end
      @(negedge clk);
      cyc++;
      vld = vld & ~last_g;
   endtask

   task automatic set_req(input int i, input logic [W-1:0] a,
                          input logic [W-1:0] b);
      vld[i] = 1'b1;
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   initial begin
      rst = 1'b1; vld = '0; rrdy = '0; inj = 1'b0;
      req_a = '0; req_b = '0;
      for (int i = 0; i < N; i++) begin
         busy[i] = 0; due[i] = 0; res[i] = '0; cnt[i] = 0;
      end
      @(negedge clk);
      step();
      step();
      rst = 1'b0;
      step();

      // single request with held response
      set_req(0, 8'd3, 8'd4);
      step();
      step();
      for (int n = 0; n < 5; n++) step();
      chk("t1_hold_c", 64'(rsp_c[8:0]), 64'd7);
      rrdy = 4'hF;
      step();
      step();

      // all four at once
      for (int i = 0; i < N; i++) set_req(i, 8'(i*10 + 1), 8'(i));
      for (int n = 0; n < 8; n++) step();

      // fairness between 1 and 3
      for (int i = 0; i < N; i++) cnt[i] = 0;
      for (int n = 0; n < 12; n++) begin
         if (!vld[1]) set_req(1, 8'($urandom), 8'($urandom));
         if (!vld[3]) set_req(3, 8'($urandom), 8'($urandom));
         step();
      end
      vld = '0;
      chk("fair_13", 64'((cnt[1] - cnt[3] <= 1) && (cnt[3] - cnt[1] <= 1)
                         && cnt[1] >= 3), 64'd1);
      step(); step(); step();

      // backpressure on requester 2
      rrdy = 4'h0;
      set_req(2, 8'd5, 8'd6);
      step();
      for (int n = 0; n < 5; n++) begin
         set_req(2, 8'd9, 8'd10);
         step();
      end
      rrdy[2] = 1'b1;
      step();
      rrdy = 4'h0;
      step();
      step(); step();
      rrdy = 4'hF;
      step();

      // operand extremes
      rrdy = 4'h0;
      set_req(0, 8'd255, 8'd255);
      set_req(3, 8'd0, 8'd0);
      step(); step(); step();
      chk("max_sum", 64'(rsp_c[8:0]), 64'h1FE);
      chk("zero_sum", 64'(rsp_c[3*(W+1) +: W+1]), 64'd0);
      rrdy = 4'hF;
      step(); step();

      // random traffic
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < N; i++) begin
            if (!vld[i]) begin
               if ($urandom % 3 == 0) set_req(i, 8'($urandom), 8'($urandom));
            end else if ($urandom % 8 == 0) begin
               vld[i] = 1'b0;
            end
         end
         rrdy = 4'($urandom);
         step();
      end
      vld = '0;
      rrdy = 4'hF;
      for (int n = 0; n < 4; n++) step();

      // reset in the cycle after a grant
      for (int i = 0; i < N; i++) set_req(i, 8'($urandom), 8'($urandom));
      step();
      vld = '0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int n = 0; n < 4; n++) step();

      // stray adder strobe
      inj = 1'b1;
      step();
      inj = 1'b0;
      for (int n = 0; n < 4; n++) step();
      chk("err_sticky", 64'(err), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      chk("err_cleared", 64'(err), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
